// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, feeding the HI/LO register file.
// Quotient goes to lo_o, remainder to hi_o; done strobes the HI/LO write enable.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             done_q;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes, one restoring step, and the final sign correction
    always_comb begin
        abs_a   = (signed_div && opdata1[WIDTH-1]) ? (-opdata1) : opdata1;
        abs_b   = (signed_div && opdata2[WIDTH-1]) ? (-opdata2) : opdata2;
        shifted = {rem, quo[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs});
        // When ge holds the true difference is below dvs, so WIDTH bits suffice
        rem_nx  = ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
        quo_nx  = {quo[WIDTH-2:0], ge};
        q_fix   = neg_q ? (-quo_nx) : quo_nx;
        r_fix   = neg_r ? (-rem_nx) : rem_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done_q <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        neg_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_r <= signed_div & opdata1[WIDTH-1];
                        if (opdata2 != '0) begin
                            rem   <= '0;
                            quo   <= abs_a;
                            dvs   <= abs_b;
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            lo_o   <= '1;
                            hi_o   <= opdata1;
                            done_q <= 1'b1;
                            state  <= FINISH;
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_STEP) begin
                            lo_o   <= q_fix;
                            hi_o   <= r_fix;
                            done_q <= 1'b1;
                            state  <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    // A flush in the commit cycle must suppress the HI/LO write
    assign done = done_q & ~cancel;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner sequences,
// and random operands checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: DIV/DIVU semantics by plain 64-bit arithmetic (truncating division)
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (!sgn) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = 32'(q);
            hi = 32'(r);
        end
    endfunction

    // Issue one start, then watch 45 cycles: first done latency, done count, busy cycles.
    // If poke > 0, a second start with other operands is driven in cycle poke.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int poke,
                           output logic [31:0] hi, output logic [31:0] lo,
                           output int lat, output int ndone, output int busy_cyc);
        lat = -1; ndone = 0; busy_cyc = 0; hi = 'x; lo = 'x;
        @(negedge clk);
        start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c; hi = hi_o; lo = lo_o;
                end
            end
            if (busy) busy_cyc++;
            start      = (c == poke);
            signed_div = 1'($urandom);
            opdata1    = $urandom;
            opdata2    = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    logic [31:0] g_hi, g_lo, e_hi, e_lo;
    int          g_lat, g_nd, g_busy, nd;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[3] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
        vecs[4] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[6] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          33};
        vecs[7] = '{1'b0, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1};

        rst = 1'b0; start = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; cancel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi",   hi_o, 32'd0);
        chk("reset_lo",   lo_o, 32'd0);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, g_hi, g_lo, g_lat, g_nd, g_busy);
            chk($sformatf("vec%0d_lo", i), g_lo, vecs[i].lo);
            chk($sformatf("vec%0d_hi", i), g_hi, vecs[i].hi);
            chk($sformatf("vec%0d_lat", i), 32'(g_lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_ndone", i), 32'(g_nd), 32'd1);
            chk($sformatf("vec%0d_busy", i), 32'(g_busy), 32'(vecs[i].lat));
        end

        // start while busy is ignored; original 100/7 result delivered
        run_div(1'b0, 32'd100, 32'd7, 5, g_hi, g_lo, g_lat, g_nd, g_busy);
        chk("busy_start_lo", g_lo, 32'd14);
        chk("busy_start_hi", g_hi, 32'd2);
        chk("busy_start_lat", 32'(g_lat), 32'd33);
        chk("busy_start_ndone", 32'(g_nd), 32'd1);

        // Cancel mid-CALC: no done, previous 100/7 result retained
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        chk("cancel_busy_before", 32'(busy), 32'd1);
        chk("cancel_done_cycle", 32'(done), 32'd0);
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy_after", 32'(busy), 32'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("cancel_no_done", 32'(nd), 32'd0);
        chk("cancel_hold_lo", lo_o, 32'd14);
        chk("cancel_hold_hi", hi_o, 32'd2);
        run_div(1'b0, 32'd9, 32'd3, 0, g_hi, g_lo, g_lat, g_nd, g_busy);
        chk("after_cancel_lo", g_lo, 32'd3);
        chk("after_cancel_hi", g_hi, 32'd0);
        chk("after_cancel_lat", 32'(g_lat), 32'd33);

        // start and cancel together in IDLE: stays idle
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel_busy", 32'(busy), 32'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        chk("start_cancel_idle", 32'(nd), 32'd0);

        // Asynchronous reset mid-CALC
        run_div(1'b0, 32'd100, 32'd7, 0, g_hi, g_lo, g_lat, g_nd, g_busy);
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_hi", hi_o, 32'd0);
        chk("arst_lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        chk("arst_no_done", 32'(nd), 32'd0);

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [31:0] a, b;
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = 32'd0 - 32'($urandom_range(1, 8));
            endcase
            if (i % 7 == 3) a = 32'h8000_0000;
            model(s, a, b, e_lo, e_hi);
            run_div(s, a, b, 0, g_hi, g_lo, g_lat, g_nd, g_busy);
            chk($sformatf("rnd%0d_lo", i), g_lo, e_lo);
            chk($sformatf("rnd%0d_hi", i), g_hi, e_hi);
            chk($sformatf("rnd%0d_lat", i), 32'(g_lat), (b == 32'd0) ? 32'd1 : 32'd33);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
